// File: rtl/ffn_pkg.sv
// Shared datapath widths and saturation helper for the FFN accumulator drain path.
package ffn_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int DATA_WIDTH = 8;

  // Signed saturation bound for a two's-complement field of the given width.
  function automatic longint sat_limit(input int width, input bit neg);
    longint lim;
    lim = longint'(1) <<< (width - 1);
    return neg ? -lim : lim - 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; the head is shown combinationally and the last
// popped word is held on the output while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i && !empty_o;
  // a simultaneous pop frees the slot, so a push while full still lands
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = empty_o ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Drains skewed systolic-array column accumulators, deskews them into rows,
// applies bias/round/shift/saturate/relu and buffers rows in an output FIFO.
module acc_requant
  import ffn_pkg::*;
#(
  parameter int N_COLS      = 4,
  parameter int ACC_WIDTH   = ffn_pkg::ACC_WIDTH,
  parameter int DATA_WIDTH  = ffn_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_COLS*ACC_WIDTH-1:0]  acc_i,
  input  logic [N_COLS-1:0]            acc_valid_i,
  input  logic [N_COLS*ACC_WIDTH-1:0]  bias_i,
  input  logic [SHIFT_WIDTH-1:0]       shift_i,
  input  logic                         relu_en_i,
  output logic [N_COLS*DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         fifo_full_o,
  output logic                         overflow_o,
  output logic                         skew_err_o
);

  // two guard bits: one for acc+bias, one for the rounding increment
  localparam int                    SW     = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0]  SAT_HI = SW'(sat_limit(DATA_WIDTH, 1'b0));
  localparam logic signed [SW-1:0]  SAT_LO = SW'(sat_limit(DATA_WIDTH, 1'b1));

  logic [N_COLS-1:0][ACC_WIDTH-1:0] r_cap_acc;
  logic [N_COLS-1:0]                r_cap_vld;
  logic [N_COLS-1:0][ACC_WIDTH-1:0] w_dly_acc;
  logic [N_COLS-1:0]                w_dly_vld;
  logic [N_COLS*DATA_WIDTH-1:0]     w_req;
  logic                             w_row_ok;
  logic                             w_skew;
  logic                             w_empty;
  logic                             r_cand_vld;
  logic [N_COLS*DATA_WIDTH-1:0]     r_cand_data;
  logic                             r_overflow;
  logic                             r_skew_err;

  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [ACC_WIDTH-1:0]   bias,
    input logic [SHIFT_WIDTH-1:0] sh,
    input logic                   relu
  );
    logic signed [SW-1:0] v;
    v = SW'(signed'(acc)) + SW'(signed'(bias));
    if (sh != '0) v = v + (SW'(1) << (sh - 1'b1));
    v = v >>> sh;
    if (v > SAT_HI)      v = SAT_HI;
    else if (v < SAT_LO) v = SAT_LO;
    if (relu && v[SW-1]) v = '0;
    return v[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap_acc <= '0;
      r_cap_vld <= '0;
    end else begin
      r_cap_acc <= acc_i;
      r_cap_vld <= acc_valid_i;
    end
  end

  // column j trails column 0 by j cycles, so it needs N_COLS-1-j extra stages
  for (genvar j = 0; j < N_COLS; j++) begin : g_col
    localparam int D = N_COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign w_dly_acc[j] = r_cap_acc[j];
      assign w_dly_vld[j] = r_cap_vld[j];
    end else begin : g_line
      logic [ACC_WIDTH-1:0] r_acc [D];
      logic [D-1:0]         r_vld;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int s = 0; s < D; s++) r_acc[s] <= '0;
          r_vld <= '0;
        end else begin
          r_acc[0] <= r_cap_acc[j];
          r_vld[0] <= r_cap_vld[j];
          for (int s = 1; s < D; s++) begin
            r_acc[s] <= r_acc[s-1];
            r_vld[s] <= r_vld[s-1];
          end
        end
      end
      assign w_dly_acc[j] = r_acc[D-1];
      assign w_dly_vld[j] = r_vld[D-1];
    end
  end

  assign w_row_ok = w_dly_vld[N_COLS-1] && (&w_dly_vld);
  assign w_skew   = w_dly_vld[N_COLS-1] ? !(&w_dly_vld) : (|w_dly_vld);

  always_comb begin
    w_req = '0;
    for (int j = 0; j < N_COLS; j++) begin
      w_req[j*DATA_WIDTH +: DATA_WIDTH] =
        requant(w_dly_acc[j], bias_i[j*ACC_WIDTH +: ACC_WIDTH], shift_i, relu_en_i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cand_vld  <= 1'b0;
      r_cand_data <= '0;
      r_overflow  <= 1'b0;
      r_skew_err  <= 1'b0;
    end else begin
      r_cand_vld <= w_row_ok;
      if (w_row_ok) r_cand_data <= w_req;
      if (w_skew) r_skew_err <= 1'b1;
      if (r_cand_vld && fifo_full_o && !out_ready_i) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (N_COLS*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (r_cand_vld),
    .data_i  (r_cand_data),
    .pop_i   (out_ready_i),
    .data_o  (out_data_o),
    .full_o  (fifo_full_o),
    .empty_o (w_empty)
  );

  assign out_valid_o = !w_empty;
  assign overflow_o  = r_overflow;
  assign skew_err_o  = r_skew_err;

endmodule

// File: tb/tb_acc_requant.sv
// Scoreboard bench for acc_requant: skewed rows in, expected rows queued at drive time.
module tb_acc_requant;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N*AW-1:0] acc_i;
  logic [N-1:0]    acc_valid_i;
  logic [N*AW-1:0] bias_i;
  logic [4:0]      shift_i;
  logic            relu_en_i;
  logic [N*DW-1:0] out_data_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            fifo_full_o;
  logic            overflow_o;
  logic            skew_err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];

  int          st_acc  [8][N];
  logic [3:0]  st_msk  [8];
  bit          st_keep [8];
  logic [31:0] st_exp  [8];
  int          cfg_bias [N];
  int          cfg_shift;
  bit          cfg_relu;

  acc_requant #(.N_COLS(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .SHIFT_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn), .acc_i(acc_i), .acc_valid_i(acc_valid_i), .bias_i(bias_i),
    .shift_i(shift_i), .relu_en_i(relu_en_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fifo_full_o(fifo_full_o), .overflow_o(overflow_o),
    .skew_err_o(skew_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int m_elem(input int a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
    if (cfg_shift > 0) s = s + (longint'(1) << (cfg_shift - 1));
    s = s >>> cfg_shift;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (cfg_relu && s < 0) s = 0;
    return int'(s);
  endfunction

  function automatic logic [31:0] model_row(input int a0, input int a1, input int a2, input int a3);
    return pack4(m_elem(a0, cfg_bias[0]), m_elem(a1, cfg_bias[1]),
                 m_elem(a2, cfg_bias[2]), m_elem(a3, cfg_bias[3]));
  endfunction

  task automatic set_cfg(input int b0, input int b1, input int b2, input int b3,
                         input int sh, input bit relu);
    cfg_bias[0] = b0; cfg_bias[1] = b1; cfg_bias[2] = b2; cfg_bias[3] = b3;
    cfg_shift = sh; cfg_relu = relu;
    for (int j = 0; j < N; j++) bias_i[j*AW +: AW] = cfg_bias[j];
    shift_i   = 5'(sh);
    relu_en_i = relu;
  endtask

  task automatic set_row(input int r, input int a0, input int a1, input int a2, input int a3,
                         input logic [3:0] msk, input bit keep, input logic [31:0] exp);
    st_acc[r][0] = a0; st_acc[r][1] = a1; st_acc[r][2] = a2; st_acc[r][3] = a3;
    st_msk[r] = msk; st_keep[r] = keep; st_exp[r] = exp;
  endtask

  // column j of row r is driven on cycle r+j; called and returns at posedge+1
  task automatic send_rows(input int n);
    for (int t = 0; t < n + N - 1; t++) begin
      for (int j = 0; j < N; j++) begin
        if (t - j >= 0 && t - j < n) begin
          acc_i[j*AW +: AW] = st_acc[t-j][j];
          acc_valid_i[j]    = st_msk[t-j][j];
        end else begin
          acc_i[j*AW +: AW] = '0;
          acc_valid_i[j]    = 1'b0;
        end
      end
      if (t - (N-1) >= 0 && st_keep[t-(N-1)]) sb.push_back(st_exp[t-(N-1)]);
      @(posedge clk); #1;
    end
    acc_i = '0;
    acc_valid_i = '0;
  endtask

  task automatic wait_drain(input bit rnd);
    int cyc = 0;
    while ((sb.size() != 0 || out_valid_o) && cyc < 300) begin
      if (rnd) out_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    out_ready_i = 1'b1;
    check_val("drain_timeout", {63'b0, cyc >= 300}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (sb.size() == 0) check_val("spurious_row", {63'b0, out_valid_o}, 64'd0);
      else check_val("row_data", {32'b0, out_data_o}, {32'b0, sb.pop_front()});
    end
  end

  initial begin
    int seen;
    int a [N];
    rstn = 1'b0; acc_i = '0; acc_valid_i = '0; out_ready_i = 1'b1;
    bias_i = '0; shift_i = '0; relu_en_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", {63'b0, out_valid_o}, 64'd0);
    check_val("rst_data", {32'b0, out_data_o}, 64'd0);
    check_val("rst_full", {63'b0, fifo_full_o}, 64'd0);
    check_val("rst_ovf", {63'b0, overflow_o}, 64'd0);
    check_val("rst_skew", {63'b0, skew_err_o}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // saturation and latency
    set_row(0, 100, 200, -50, -300, 4'hF, 1, pack4(100, 127, -50, -128));
    send_rows(1);
    @(posedge clk); #1;
    check_val("lat_k1_valid", {63'b0, out_valid_o}, 64'd0);
    @(posedge clk); #1;
    check_val("lat_k2_valid", {63'b0, out_valid_o}, 64'd1);
    wait_drain(0);
    check_val("hold_last", {32'b0, out_data_o}, {32'b0, pack4(100, 127, -50, -128)});

    // rounding shift
    set_cfg(0, 0, 0, 0, 1, 0);
    set_row(0, 5, 6, -5, -6, 4'hF, 1, pack4(3, 3, -2, -3));
    send_rows(1);
    wait_drain(0);

    // relu with bias
    set_cfg(5, -20, 2, -1, 0, 1);
    set_row(0, -10, 10, 40, 0, 4'hF, 1, pack4(0, 0, 42, 0));
    send_rows(1);
    wait_drain(0);

    // overflow: five rows into a four-deep FIFO with the consumer stalled
    set_cfg(0, 0, 0, 0, 0, 0);
    check_val("pre_ovf", {63'b0, overflow_o}, 64'd0);
    out_ready_i = 1'b0;
    for (int r = 0; r < 5; r++)
      set_row(r, r*16 - 30, r*3 + 1, -r*7, 90 - r, 4'hF, r < 4,
              model_row(r*16 - 30, r*3 + 1, -r*7, 90 - r));
    send_rows(5);
    repeat (3) @(posedge clk);
    #1;
    check_val("full_after4", {63'b0, fifo_full_o}, 64'd1);
    check_val("ovf_set", {63'b0, overflow_o}, 64'd1);
    out_ready_i = 1'b1;
    wait_drain(0);
    check_val("full_cleared", {63'b0, fifo_full_o}, 64'd0);

    // skew: column 2 withheld on the first row only
    check_val("pre_skew", {63'b0, skew_err_o}, 64'd0);
    set_row(0, 11, 22, 33, 44, 4'b1011, 0, '0);
    set_row(1, -1, -2, 60, 70, 4'hF, 1, model_row(-1, -2, 60, 70));
    send_rows(2);
    wait_drain(0);
    check_val("skew_set", {63'b0, skew_err_o}, 64'd1);

    // randomized batches with random backpressure
    for (int b = 0; b < 6; b++) begin
      set_cfg(int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 6000)) - 3000,
              int'($urandom_range(0, 6000)) - 3000, int'($urandom_range(0, 6000)) - 3000,
              int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < N; j++)
          a[j] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 8000)) - 4000;
        set_row(r, a[0], a[1], a[2], a[3], 4'hF, 1, model_row(a[0], a[1], a[2], a[3]));
      end
      send_rows(3);
      wait_drain(1);
    end

    // reset with two rows buffered and one in the deskew line
    set_cfg(0, 0, 0, 0, 0, 0);
    out_ready_i = 1'b0;
    set_row(0, 1, 2, 3, 4, 4'hF, 0, '0);
    set_row(1, 5, 6, 7, 8, 4'hF, 0, '0);
    send_rows(2);
    repeat (3) @(posedge clk);
    #1;
    check_val("buffered_valid", {63'b0, out_valid_o}, 64'd1);
    acc_i[0*AW +: AW] = 77; acc_valid_i = 4'b0001;
    @(posedge clk); #1;
    acc_i = '0; acc_i[1*AW +: AW] = 78; acc_valid_i = 4'b0010;
    @(posedge clk); #1;
    rstn = 1'b0;
    #2;
    check_val("mid_rst_valid", {63'b0, out_valid_o}, 64'd0);
    check_val("mid_rst_data", {32'b0, out_data_o}, 64'd0);
    check_val("mid_rst_full", {63'b0, fifo_full_o}, 64'd0);
    check_val("mid_rst_ovf", {63'b0, overflow_o}, 64'd0);
    check_val("mid_rst_skew", {63'b0, skew_err_o}, 64'd0);
    acc_i = '0; acc_valid_i = '0;
    sb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready_i = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_o) seen++;
    end
    check_val("no_row_after_rst", 64'(seen), 64'd0);
    check_val("skew_after_rst", {63'b0, skew_err_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_requant.md
ACC_REQUANT -- requirements
Module: acc_requant

Interface
REQ-001 The block SHALL have parameter N_COLS, default 4: number of systolic-array columns drained.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32: width of each column accumulator.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8: width of each requantized output element.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: output rows buffered, power of two.
REQ-005 The block SHALL have parameter SHIFT_WIDTH, default 5: width of the requant shift amount.
REQ-006 Port clk, input, 1 bit: clock, all state on rising edge.
REQ-007 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port acc_i, input, N_COLS*ACC_WIDTH bits: signed column accumulators, column j in slice j.
REQ-009 Port acc_valid_i, input, N_COLS bits: per-column valid; column j of a row arrives j cycles after column 0.
REQ-010 Port bias_i, input, N_COLS*ACC_WIDTH bits: signed per-column bias, quasi-static.
REQ-011 Port shift_i, input, SHIFT_WIDTH bits: arithmetic right-shift amount, quasi-static.
REQ-012 Port relu_en_i, input, 1 bit: clamp negative results to 0 when 1.
REQ-013 Port out_data_o, output, N_COLS*DATA_WIDTH bits: signed requantized row, column j in slice j.
REQ-014 Port out_valid_o, output, 1 bit: out_data_o holds a valid row.
REQ-015 Port out_ready_i, input, 1 bit: consumer accepts the row when out_valid_o && out_ready_i.
REQ-016 Port fifo_full_o, output, 1 bit: FIFO holds FIFO_DEPTH rows; controller uses it to stop issuing.
REQ-017 Port overflow_o, output, 1 bit: sticky, a row was dropped because the FIFO was full.
REQ-018 Port skew_err_o, output, 1 bit: sticky, aligned column valids disagreed.

Function
REQ-019 Deskew: column j SHALL pass through a register delay line of N_COLS-1-j stages (data and valid), so all columns of a row align on the cycle column N_COLS-1 arrives.
REQ-020 A row SHALL be aligned when the delayed valid of column N_COLS-1 is 1; if any other delayed valid differs on that cycle, or any is 1 while column N_COLS-1 is 0, skew_err_o SHALL be set and the row discarded.
REQ-021 Per column: sum = acc + bias, computed at ACC_WIDTH+1 bits with sign extension, no wrap.
REQ-022 Rounding: if shift>0 add 2^(shift-1) to sum, then arithmetic right shift by shift (round half up toward +inf).
REQ-023 Saturate the shifted value to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; then if relu_en_i, negative values become 0.
REQ-024 Requant results SHALL be registered one cycle after alignment, forming a push candidate with a valid bit.
REQ-025 The push candidate SHALL be written to a FIFO of FIFO_DEPTH rows; out_data_o/out_valid_o SHALL reflect the FIFO head.
REQ-026 Latency: column N_COLS-1 valid sampled at edge k, FIFO empty, gives out_valid_o=1 after edge k+2.
REQ-027 The upstream array cannot stall: a push while full with no pop SHALL drop the row and set overflow_o; a push and pop in the same cycle while full SHALL both succeed.
REQ-028 Pop on empty SHALL have no effect; out_data_o SHALL hold its last value while out_valid_o=0.
REQ-029 Rows SHALL leave in arrival order; one row per cycle sustained throughput when out_ready_i=1.
REQ-030 overflow_o and skew_err_o SHALL clear only on reset.

Reset
REQ-031 Asserting rstn low SHALL asynchronously clear delay lines, push candidate, FIFO pointers/count, and all sticky flags.
REQ-032 Reset values: out_valid_o=0, out_data_o=0, fifo_full_o=0, overflow_o=0, skew_err_o=0.
REQ-033 Reset mid-operation SHALL discard all in-flight and buffered rows; no partial row is emitted after release.

Structure
REQ-034 DATA_WIDTH, ACC_WIDTH and a saturation-limit constant function SHALL live in the shared ffn_pkg package.
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo (parameterized width and depth, count-based full/empty).

Verification (N_COLS=4, DATA_WIDTH=8, bias 0, shift 0, relu off unless stated)
REQ-036 Skewed row acc=[100,200,-50,-300] -> out [100,127,-50,-128], out_valid two cycles after column 3.
REQ-037 shift=1, acc=[5,6,-5,-6] -> out [3,3,-2,-3].
REQ-038 relu on, acc=[-10,10,40,0], bias=[5,-20,2,-1] -> out [0,0,42,0].
REQ-039 out_ready_i=0, five back-to-back rows -> fifo_full_o=1 after four, fifth dropped, overflow_o=1; then ready=1 drains four rows in order.
REQ-040 Column 2 valid withheld for one row -> skew_err_o=1, that row absent, next row correct.
REQ-041 rstn pulsed low with two rows buffered and one in deskew -> all outputs 0, no row emitted after release.
